// File: rtl/register_file_pkg.sv
// Shared datapath widths and register-index constants for the single-cycle MIPS-style core.
// Reused by the ALU, control unit and top-level datapath.
package register_file_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file.sv
// 32 x 32-bit register file: two bypassed combinational read ports, one write port,
// an unbypassed debug read port and a per-register "written since reset" bitmap.
module register_file
    import register_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [NREGS-1:0]  written
);

    word_t            regs_q [NREGS];
    logic [NREGS-1:0] written_q;

    logic wr_active;
    assign wr_active = wr_en && (wr_addr != REG_ZERO);

    // regs_q[0] is never written, so it stays zero after the first reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            written_q <= '0;
        end else if (wr_active) begin
            regs_q[wr_addr]    <= wr_data;
            written_q[wr_addr] <= 1'b1;
        end
    end

    function automatic word_t read_port(input reg_idx_t addr,
                                        input word_t    stored,
                                        input logic     we,
                                        input reg_idx_t wa,
                                        input word_t    wd);
        word_t res;
        if (addr == REG_ZERO) begin
            res = '0;
        end else if (we && (wa == addr)) begin
            res = wd;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1, regs_q[rd_addr1], wr_en, wr_addr, wr_data);
        rd_data2 = read_port(rd_addr2, regs_q[rd_addr2], wr_en, wr_addr, wr_data);
        dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs_q[dbg_addr];
    end

    assign written = written_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; includes a tiny ALU model (sub, slt) for the write-back loop.
module tb_register_file;
    import register_file_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, dbg_addr;
    logic [DATA_W-1:0] rd_data1, rd_data2, wr_data, dbg_data;
    logic              wr_en;
    logic [NREGS-1:0]  written;

    int total = 0;
    int bad   = 0;

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .written  (written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        case (op)
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            default: return '0;
        endcase
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr1 = '0; rd_addr2 = '0; dbg_addr = '0;
        step();
        rst = 1'b0;
        check("reset_written", written, 32'h0);
        dbg_addr = 5'd12; #1;
        check("reset_dbg12", dbg_data, 32'h0);

        // Fill every register, then reset.
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA000_0000 | 32'(i));
        check("fill_written", written, 32'hFFFF_FFFE);
        dbg_addr = 5'd17; #1;
        check("fill_dbg17", dbg_data, 32'hA000_0011);
        rst = 1'b1; dbg_addr = 5'd9; #1;
        check("rst_cycle_dbg9", dbg_data, 32'hA000_0009);
        step();
        rst = 1'b0;
        check("rst_written", written, 32'h0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            check($sformatf("rst_dbg%0d", i), dbg_data, 32'h0);
        end

        // Basic write / read.
        write_reg(5'd5, 32'hDEADBEEF);
        write_reg(5'd6, 32'h0000000A);
        rd_addr1 = 5'd5; rd_addr2 = 5'd6; #1;
        check("rd1_r5", rd_data1, 32'hDEADBEEF);
        check("rd2_r6", rd_data2, 32'h0000000A);
        check("written_6_5", 32'(written[6:5]), 32'h3);

        // Zero register ignores writes.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr1 = 5'd0; #1;
        check("r0_same_cycle", rd_data1, 32'h0);
        step();
        wr_en = 1'b0;
        check("r0_after_edge", rd_data1, 32'h0);
        check("written0", 32'(written[0]), 32'h0);
        dbg_addr = 5'd0; #1;
        check("dbg_r0", dbg_data, 32'h0);

        // Bypass on both ports; debug port shows the stored value only.
        write_reg(5'd7, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h4;
        rd_addr1 = 5'd7; rd_addr2 = 5'd7; dbg_addr = 5'd7; #1;
        check("bypass_rd1", rd_data1, 32'h4);
        check("bypass_rd2", rd_data2, 32'h4);
        check("bypass_dbg_before", dbg_data, 32'h1);
        step();
        wr_en = 1'b0;
        check("bypass_dbg_after", dbg_data, 32'h4);
        // Bypass only on port 2 while port 1 reads stored data.
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h77; rd_addr1 = 5'd5; rd_addr2 = 5'd6; #1;
        check("bypass_rd2_only", rd_data2, 32'h77);
        check("nobypass_rd1", rd_data1, 32'hDEADBEEF);
        wr_en = 1'b0; #1;
        check("nobypass_rd2", rd_data2, 32'h0000000A);

        // Reset wins over a same-cycle write.
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        step();
        rst = 1'b0; wr_en = 1'b0;
        dbg_addr = 5'd3; #1;
        check("collide_r3", dbg_data, 32'h0);
        check("collide_written3", 32'(written[3]), 32'h0);
        check("collide_written", written, 32'h0);

        // ALU write-back loop: r3 = r1 - r2, then r4 = slt(r1, r2).
        write_reg(5'd1, 32'd4);
        write_reg(5'd2, 32'd10);
        rd_addr1 = 5'd1; rd_addr2 = 5'd2; #1;
        write_reg(5'd3, alu(3'b110, rd_data1, rd_data2));
        dbg_addr = 5'd3; #1;
        check("alu_sub_r3", dbg_data, 32'hFFFFFFFA);
        write_reg(5'd4, alu(3'b111, rd_data1, rd_data2));
        dbg_addr = 5'd4; #1;
        check("alu_slt_r4", dbg_data, 32'h1);
        check("alu_written", written, 32'h0000_001E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
